uart_rx_cmd_ctrl: RTL and testbench



---
 rtl/uart_rx_cmd_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - UART RX command sequencer: frame assembly, regfile/ALU strobes, response channel
// Optional feature macro: CMD_ERR_CNT_EN (adds saturating err_cnt output)
module uart_rx_cmd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     rx_p_data,
    input  logic                  rx_d_vld,
    input  logic                  rx_par_err,
    input  logic                  rx_frm_err,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_data_vld,
    output logic                  alu_en,
    output logic [3:0]            alu_fun,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_vld,
    output logic                  clk_gate_en,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  frame_err,
    output logic                  cmd_err
`ifdef CMD_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU  = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALUN = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, ALU_FUN, ALU_WAIT, RSP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    tmo_cnt, tmo_cnt_nxt;
    logic [DATA_W-1:0]   hi_byte, hi_byte_nxt;
    logic                hi_pend, hi_pend_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wr_data_nxt, rsp_data_nxt;
    logic [3:0]          alu_fun_nxt;
    logic                wr_en_nxt, rd_en_nxt, alu_en_nxt, clk_gate_nxt;
    logic                rsp_valid_nxt, frame_err_nxt, cmd_err_nxt;
    logic                collecting;

    always_comb begin
        state_nxt     = state;
        tmo_cnt_nxt   = '0;
        hi_byte_nxt   = hi_byte;
        hi_pend_nxt   = hi_pend;
        addr_nxt      = addr;
        wr_data_nxt   = wr_data;
        rsp_data_nxt  = rsp_data;
        alu_fun_nxt   = alu_fun;
        rsp_valid_nxt = rsp_valid;
        wr_en_nxt     = 1'b0;
        rd_en_nxt     = 1'b0;
        alu_en_nxt    = 1'b0;
        frame_err_nxt = 1'b0;
        cmd_err_nxt   = 1'b0;
        collecting    = state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN};

        if (collecting || state == IDLE) begin
            if (rx_d_vld && (rx_par_err || rx_frm_err)) begin
                frame_err_nxt = 1'b1;
                state_nxt     = IDLE;
            end else if (rx_d_vld) begin
                case (state)
                    IDLE: begin
                        if (rx_p_data == CMD_WR)        state_nxt = WR_ADDR;
                        else if (rx_p_data == CMD_RD)   state_nxt = RD_ADDR;
                        else if (rx_p_data == CMD_ALU)  state_nxt = OP_A;
                        else if (rx_p_data == CMD_ALUN) state_nxt = ALU_FUN;
                        else                            cmd_err_nxt = 1'b1;
                    end
                    WR_ADDR: begin
                        addr_nxt  = rx_p_data[ADDR_W-1:0];
                        state_nxt = WR_DATA;
                    end
                    WR_DATA: begin
                        wr_data_nxt = rx_p_data;
                        wr_en_nxt   = 1'b1;
                        state_nxt   = IDLE;
                    end
                    RD_ADDR: begin
                        addr_nxt  = rx_p_data[ADDR_W-1:0];
                        rd_en_nxt = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                    OP_A, OP_B: begin
                        addr_nxt    = (state == OP_A) ? ADDR_W'(0) : ADDR_W'(1);
                        wr_data_nxt = rx_p_data;
                        wr_en_nxt   = 1'b1;
                        state_nxt   = (state == OP_A) ? OP_B : ALU_FUN;
                    end
                    ALU_FUN: begin
                        alu_fun_nxt = rx_p_data[3:0];
                        alu_en_nxt  = 1'b1;
                        state_nxt   = ALU_WAIT;
                    end
                    default: ;
                endcase
            end else if (collecting) begin
                // Idle gap inside a frame: abort once the gap reaches TIMEOUT_CYC cycles
                if (tmo_cnt == TMO_LAST) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
        end else begin
            if (rx_d_vld) cmd_err_nxt = 1'b1;
            case (state)
                RD_WAIT: if (rd_data_vld) begin
                    rsp_data_nxt  = rd_data;
                    rsp_valid_nxt = 1'b1;
                    hi_pend_nxt   = 1'b0;
                    state_nxt     = RSP;
                end
                ALU_WAIT: if (alu_out_vld) begin
                    rsp_data_nxt  = alu_out[DATA_W-1:0];
                    hi_byte_nxt   = alu_out[2*DATA_W-1:DATA_W];
                    hi_pend_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RSP;
                end
                RSP: if (rsp_valid && rsp_ready) begin
                    if (hi_pend) begin
                        rsp_data_nxt = hi_byte;
                        hi_pend_nxt  = 1'b0;
                    end else begin
                        rsp_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Gate stays open from ALU_FUN entry until the result arrives or the frame aborts
        clk_gate_nxt = (state_nxt == ALU_FUN) || (state_nxt == ALU_WAIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            hi_byte     <= '0;
            hi_pend     <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            rsp_data    <= '0;
            alu_fun     <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            alu_en      <= 1'b0;
            clk_gate_en <= 1'b0;
            rsp_valid   <= 1'b0;
            frame_err   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            hi_byte     <= hi_byte_nxt;
            hi_pend     <= hi_pend_nxt;
            addr        <= addr_nxt;
            wr_data     <= wr_data_nxt;
            rsp_data    <= rsp_data_nxt;
            alu_fun     <= alu_fun_nxt;
            wr_en       <= wr_en_nxt;
            rd_en       <= rd_en_nxt;
            alu_en      <= alu_en_nxt;
            clk_gate_en <= clk_gate_nxt;
            rsp_valid   <= rsp_valid_nxt;
            frame_err   <= frame_err_nxt;
            cmd_err     <= cmd_err_nxt;
        end
    end

`ifdef CMD_ERR_CNT_EN
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + 9'(frame_err_nxt) + 9'(cmd_err_nxt);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) err_cnt <= '0;
        else      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb/tb_uart_rx_cmd_ctrl.sv - randomized scoreboard bench for uart_rx_cmd_ctrl
module tb_uart_rx_cmd_ctrl;
    localparam int TMO = 4095;

    logic        CLK = 1'b0, RST = 1'b0;
    logic [7:0]  rx_p_data = '0;
    logic        rx_d_vld = 1'b0, rx_par_err = 1'b0, rx_frm_err = 1'b0;
    logic        wr_en, rd_en, alu_en, clk_gate_en, rsp_valid, frame_err, cmd_err;
    logic [3:0]  addr, alu_fun;
    logic [7:0]  wr_data, rsp_data;
    logic [7:0]  rd_data = '0;
    logic        rd_data_vld = 1'b0, alu_out_vld = 1'b0, rsp_ready = 1'b0;
    logic [15:0] alu_out = '0;
`ifdef CMD_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    uart_rx_cmd_ctrl #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
        .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_vld(alu_out_vld),
        .clk_gate_en(clk_gate_en), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .frame_err(frame_err), .cmd_err(cmd_err)
`ifdef CMD_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0, passes = 0, rsp_xfers = 0, err_total = 0;
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  alu_q[$];
    logic [7:0]  rsp_q[$];
    int          err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic void push_err(input int code);
        err_q.push_back(code);
        err_total++;
    endfunction

    // Monitor: every DUT output event is matched against the head of its queue
    always @(negedge CLK) if (RST) begin
        if (wr_en) begin
            if (wr_q.size() == 0) flag("wr_en", {addr, wr_data});
            else check("wr addr/data", {20'h0, addr, wr_data}, {20'h0, wr_q.pop_front()});
        end
        if (rd_en) begin
            if (rd_q.size() == 0) flag("rd_en", addr);
            else check("rd addr", addr, rd_q.pop_front());
        end
        if (alu_en) begin
            if (alu_q.size() == 0) flag("alu_en", alu_fun);
            else check("alu_fun", alu_fun, alu_q.pop_front());
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) flag("rsp_valid", rsp_data);
            else begin
                check("rsp_data", rsp_data, rsp_q[0]);
                if (rsp_ready) begin
                    void'(rsp_q.pop_front());
                    rsp_xfers++;
                end
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) flag("frame_err", 1);
            else check("err kind (1=frame)", err_q.pop_front(), 1);
        end
        if (cmd_err) begin
            if (err_q.size() == 0) flag("cmd_err", 1);
            else check("err kind (2=cmd)", err_q.pop_front(), 2);
        end
    end

    task automatic send(input logic [7:0] b, input logic pe, input logic fe, input int gap);
        repeat (gap) @(posedge CLK);
        @(posedge CLK); #1;
        rx_p_data = b; rx_d_vld = 1'b1; rx_par_err = pe; rx_frm_err = fe;
        @(posedge CLK); #1;
        rx_d_vld = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0; rx_p_data = 8'($urandom);
    endtask

    task automatic pulse_rd(input logic [7:0] d, input int gap);
        repeat (gap) @(posedge CLK);
        @(posedge CLK); #1; rd_data = d; rd_data_vld = 1'b1;
        @(posedge CLK); #1; rd_data_vld = 1'b0; rd_data = 8'($urandom);
    endtask

    task automatic pulse_alu(input logic [15:0] v, input int gap);
        repeat (gap) @(posedge CLK);
        @(posedge CLK); #1; alu_out = v; alu_out_vld = 1'b1;
        @(posedge CLK); #1; alu_out_vld = 1'b0; alu_out = 16'($urandom);
    endtask

    task automatic drain_rsp(input int n, input int hold);
        int target = rsp_xfers + n;
        int budget = 300;
        rsp_ready = 1'b0;
        repeat (hold) @(posedge CLK);
        while (rsp_xfers < target && budget > 0) begin
            @(posedge CLK); #1;
            rsp_ready = (hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            budget--;
        end
        rsp_ready = 1'b0;
        if (rsp_xfers < target) flag("rsp drain timeout", rsp_xfers);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
        wr_q.push_back({a[3:0], d});
        send(8'hAA, 0, 0, gap); send(a, 0, 0, gap); send(d, 0, 0, gap);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d, input int gap,
                           input bit stray, input int hold);
        rd_q.push_back(a[3:0]);
        rsp_q.push_back(d);
        send(8'hBB, 0, 0, gap); send(a, 0, 0, gap);
        if (stray) begin push_err(2); send(8'($urandom), 0, 0, 0); end
        pulse_rd(d, gap);
        if (stray) begin push_err(2); send(8'($urandom), 0, 0, 0); end
        drain_rsp(1, hold);
    endtask

    task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input logic [15:0] v, input int gap);
        if (with_ops) begin
            wr_q.push_back({4'd0, a});
            wr_q.push_back({4'd1, b});
            send(8'hCC, 0, 0, gap); send(a, 0, 0, gap); send(b, 0, 0, gap);
        end else begin
            send(8'hDD, 0, 0, gap);
        end
        alu_q.push_back(f[3:0]);
        rsp_q.push_back(v[7:0]);
        rsp_q.push_back(v[15:8]);
        check("clk_gate_en in ALU_FUN", clk_gate_en, 1);
        send(f, 0, 0, gap);
        check("clk_gate_en in ALU_WAIT", clk_gate_en, 1);
        pulse_alu(v, gap);
        check("clk_gate_en after alu_out_vld", clk_gate_en, 0);
        drain_rsp(2, 0);
    endtask

    // Send a prefix of k good bytes of a frame, then a corrupted byte
    task automatic do_err_frame(input int kind, input int k, input int gap);
        logic [7:0] fb[4];
        logic [1:0] ef;
        fb[0] = (kind == 0) ? 8'hAA : (kind == 1) ? 8'hBB : (kind == 2) ? 8'hCC : 8'hDD;
        for (int i = 1; i < 4; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < k; i++) begin
            if (kind == 2 && (i == 1 || i == 2)) wr_q.push_back({4'(i - 1), fb[i]});
            send(fb[i], 0, 0, gap);
        end
        ef = 2'($urandom_range(1, 3));
        push_err(1);
        send(8'($urandom), ef[0], ef[1], gap);
        check("clk_gate_en after abort", clk_gate_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int len;
        repeat (3) @(posedge CLK);
        #1;
        check("reset wr_en", wr_en, 0);          check("reset rd_en", rd_en, 0);
        check("reset alu_en", alu_en, 0);        check("reset rsp_valid", rsp_valid, 0);
        check("reset clk_gate_en", clk_gate_en, 0);
        check("reset frame_err", frame_err, 0);  check("reset cmd_err", cmd_err, 0);
        check("reset addr", addr, 0);            check("reset rsp_data", rsp_data, 0);
        RST = 1'b1;

        do_write(8'h05, 8'h3C, 0);
        do_read(8'h07, 8'h5A, 0, 0, 3);
        do_alu(1, 8'h10, 8'h20, 8'h00, 16'h0030, 0);
        send(8'hAA, 0, 0, 0); send(8'h03, 0, 0, 0);
        push_err(1);
        send(8'h44, 1, 0, 0);
        do_write(8'h01, 8'hFF, 0);
        push_err(2);
        send(8'h77, 0, 0, 0);

        // Timeout boundary: a gap one cycle short of expiry keeps the frame alive
        do_write(8'h05, 8'h3C, TMO - 2);
        send(8'hAA, 0, 0, 0);
        push_err(1);
        repeat (TMO) @(posedge CLK);
        push_err(2);
        send(8'h05, 0, 0, 0);
        send(8'hDD, 0, 0, 0);
        repeat (TMO - 2) @(posedge CLK);
        check("clk_gate_en before timeout", clk_gate_en, 1);
        push_err(1);
        repeat (4) @(posedge CLK);
        check("clk_gate_en after timeout", clk_gate_en, 0);

        // Reset mid-frame: the partial write is lost, 3C lands in IDLE
        send(8'hAA, 0, 0, 0); send(8'h05, 0, 0, 0);
        RST = 1'b0;
        #1;
        check("mid-frame reset addr", addr, 0);
        check("mid-frame reset wr_en", wr_en, 0);
        @(posedge CLK); #1; RST = 1'b1;
        push_err(2);
        send(8'h3C, 0, 0, 0);

        for (int it = 0; it < 80; it++) begin
            int gap = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: do_write(8'($urandom), 8'($urandom), gap);
                1: do_read(8'($urandom), 8'($urandom), gap, 1'($urandom_range(0, 1)), 0);
                2: do_alu(1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), gap);
                3: do_alu(0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), gap);
                4: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    push_err(2);
                    send(b, 0, 0, gap);
                end
                default: begin
                    int kind = $urandom_range(0, 3);
                    len = (kind == 0) ? 3 : (kind == 1) ? 2 : (kind == 2) ? 4 : 2;
                    do_err_frame(kind, $urandom_range(0, len - 1), gap);
                end
            endcase
        end

`ifdef CMD_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            push_err(2);
            send(8'h77, 0, 0, 0);
        end
`endif
        repeat (20) @(posedge CLK);
        #1;
        check("wr queue drained", wr_q.size(), 0);
        check("rd queue drained", rd_q.size(), 0);
        check("alu queue drained", alu_q.size(), 0);
        check("rsp queue drained", rsp_q.size(), 0);
        check("err queue drained", err_q.size(), 0);
`ifdef CMD_ERR_CNT_EN
        check("err_cnt saturating", err_cnt, (err_total > 255) ? 255 : err_total);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
